// File: rtl/jh_nbank_fifo_pkg.sv
// Shared helpers for the banked FIFO: pointer-to-bank and pointer-to-address decode,
// plus the prefetch occupancy type.
package jh_nbank_fifo_pkg;

  localparam int unsigned DEF_FIFO_DEPTH = 16;
  localparam int unsigned DEF_NUM_BANKS  = 2;
  localparam int unsigned DEF_BANK_BITS  = $clog2(DEF_NUM_BANKS);
  localparam int unsigned DEF_ADDR_BITS  =
    $clog2(DEF_FIFO_DEPTH / DEF_NUM_BANKS);

  typedef logic [1:0] pf_occ_t;

  // Low pointer bits select the bank so consecutive entries rotate.
  function automatic logic [31:0] bank_of(
    input logic [31:0] ptr,
    input int unsigned bank_bits = DEF_BANK_BITS
  );
    return ptr & ((32'd1 << bank_bits) - 32'd1);
  endfunction

  function automatic logic [31:0] addr_of(
    input logic [31:0] ptr,
    input int unsigned bank_bits = DEF_BANK_BITS,
    input int unsigned addr_bits = DEF_ADDR_BITS
  );
    return (ptr >> bank_bits) & ((32'd1 << addr_bits) - 32'd1);
  endfunction

endpackage

// File: rtl/jh_external_nbank_interleaved_fifo_prefetch_buf.sv
// Two-entry registered skid buffer that absorbs RAM read data ahead of the consumer.
// Head entry drives the output directly, so there is no path from the load port.
module jh_fifo_prefetch_buf
  import jh_nbank_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output pf_occ_t               occ
);

  logic [DATA_WIDTH-1:0] e0_q, e0_d;
  logic [DATA_WIDTH-1:0] e1_q, e1_d;
  pf_occ_t               occ_q, occ_d;
  logic                  pop;
  logic                  do_both, do_pop, do_load;

  assign pop     = (occ_q != 2'd0) && out_ready;
  assign do_both = !flush && pop && load;
  assign do_pop  = !flush && pop && !load;
  assign do_load = !flush && !pop && load;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    occ_d = occ_q;
    unique case (1'b1)
      flush: occ_d = 2'd0;
      do_both: begin
        if (occ_q == 2'd2) begin
          e0_d = e1_q;
          e1_d = load_data;
        end else begin
          e0_d = load_data;
        end
      end
      do_pop: begin
        e0_d  = e1_q;
        occ_d = occ_q - 2'd1;
      end
      do_load: begin
        if (occ_q == 2'd0) e0_d = load_data;
        else               e1_d = load_data;
        occ_d = occ_q + 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      occ_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      occ_q <= occ_d;
    end
  end

  assign out_data  = e0_q;
  assign out_valid = (occ_q != 2'd0);
  assign occ       = occ_q;

endmodule

// File: rtl/jh_external_nbank_interleaved_fifo.sv
// Valid/ready FIFO over NUM_BANKS external single-port RAMs, entries interleaved by bank.
// Optional sticky ovf_err/udf_err outputs under JH_NBANK_FIFO_ERR_FLAGS_EN.
module jh_external_nbank_interleaved_fifo
  import jh_nbank_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_BANKS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic [NUM_BANKS*$clog2(FIFO_DEPTH/NUM_BANKS)-1:0] mem_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] mem_din,
  output logic [NUM_BANKS-1:0]  mem_wr_en,
  output logic [NUM_BANKS-1:0]  mem_rd_en,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0] mem_dout
`ifdef JH_NBANK_FIFO_ERR_FLAGS_EN
  ,
  output logic                  ovf_err,
  output logic                  udf_err
`endif
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BB = $clog2(NUM_BANKS);
  localparam int unsigned AW = $clog2(FIFO_DEPTH / NUM_BANKS);
  localparam int unsigned DW = DATA_WIDTH;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] pop_ptr_q, pop_ptr_d;
  logic          ifl_q, ifl_d;
  logic [BB-1:0] ifl_bank_q, ifl_bank_d;

  logic [BB-1:0] wr_bank, rd_bank;
  logic [AW-1:0] wr_addr, rd_addr;
  logic          push, pop, rd_issue;
  logic          credit_ok;
  pf_occ_t       occ;

  assign wr_bank = BB'(bank_of(32'(wr_ptr_q), BB));
  assign rd_bank = BB'(bank_of(32'(rd_ptr_q), BB));
  assign wr_addr = AW'(addr_of(32'(wr_ptr_q), BB, AW));
  assign rd_addr = AW'(addr_of(32'(rd_ptr_q), BB, AW));

  assign count    = wr_ptr_q - pop_ptr_q;
  assign in_ready = (count < PW'(FIFO_DEPTH));
  assign push     = in_valid && in_ready && !clear;
  assign pop      = out_valid && out_ready && !clear;

  // A same-cycle pop frees a buffer slot, which keeps reads flowing at 1/cycle.
  assign credit_ok = ({1'b0, occ} + {2'b00, ifl_q}) < ({2'b00, pop} + 3'd2);
  assign rd_issue  = !clear && (rd_ptr_q != wr_ptr_q) && credit_ok &&
                     !(push && (rd_bank == wr_bank));

  always_comb begin
    mem_wr_en = '0;
    mem_rd_en = '0;
    mem_addr  = '0;
    mem_din   = '0;
    if (push) begin
      mem_wr_en[wr_bank]              = 1'b1;
      mem_addr[int'(wr_bank)*AW +: AW] = wr_addr;
      mem_din[int'(wr_bank)*DW +: DW]  = in_data;
    end
    if (rd_issue) begin
      mem_rd_en[rd_bank]              = 1'b1;
      mem_addr[int'(rd_bank)*AW +: AW] = rd_addr;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q + PW'(push);
    rd_ptr_d   = rd_ptr_q + PW'(rd_issue);
    pop_ptr_d  = pop_ptr_q + PW'(pop);
    ifl_d      = rd_issue;
    ifl_bank_d = rd_issue ? rd_bank : ifl_bank_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      pop_ptr_d  = '0;
      ifl_d      = 1'b0;
      ifl_bank_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      pop_ptr_q  <= '0;
      ifl_q      <= 1'b0;
      ifl_bank_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      pop_ptr_q  <= pop_ptr_d;
      ifl_q      <= ifl_d;
      ifl_bank_q <= ifl_bank_d;
    end
  end

  jh_fifo_prefetch_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_pf (
    .clk      (clk),
    .rst      (rst),
    .flush    (clear),
    .load     (ifl_q),
    .load_data(mem_dout[int'(ifl_bank_q)*DW +: DW]),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .occ      (occ)
  );

`ifdef JH_NBANK_FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;

  always_comb begin
    ovf_d = ovf_q | (in_valid & ~in_ready);
    udf_d = udf_q | (out_ready & ~out_valid);
    if (clear) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign ovf_err = ovf_q;
  assign udf_err = udf_q;
`endif

endmodule
